// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state, opcode and select encodings for the
// multi-cycle MIPS control sequencer (mc_control_fsm, mc_ctrl_decode).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_JAL      = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12,
    S_JR       = 4'd13,
    S_HALT     = 4'd14,
    S_UNUSED   = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_IMM   = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_A      = 2'b11;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MDR = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC  = 2'b10;

  localparam logic [1:0] ALU_B_REG   = 2'b00;
  localparam logic [1:0] ALU_B_FOUR  = 2'b01;
  localparam logic [1:0] ALU_B_IMM   = 2'b10;
  localparam logic [1:0] ALU_B_IMMSH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational map from (state, mem_ready) to the control
// bundle. Only FETCH and MEM_WR look at mem_ready; everything else is Moore.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  // Per-state strobe decode; unlisted strobes stay 0.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = ALU_B_FOUR;
        ctrl_o.alu_op    = ALU_OP_ADD;
        ctrl_o.pc_source = PC_SRC_ALU;
        ctrl_o.pc_write  = mem_ready_i;
        ctrl_o.ir_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = ALU_B_IMMSH;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALU_B_IMM;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.i_or_d   = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_dst    = REG_DST_RT;
        ctrl_o.mem_to_reg = MEM_TO_REG_MDR;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.i_or_d     = 1'b1;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALU_B_REG;
        ctrl_o.alu_op    = ALU_OP_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_dst    = REG_DST_RD;
        ctrl_o.mem_to_reg = MEM_TO_REG_ALU;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = ALU_B_REG;
        ctrl_o.alu_op        = ALU_OP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PC_SRC_ALUOUT;
        ctrl_o.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PC_SRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      S_JAL: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PC_SRC_JUMP;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = REG_DST_RA;
        ctrl_o.mem_to_reg = MEM_TO_REG_PC;
        ctrl_o.instr_done = 1'b1;
      end
      S_I_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALU_B_IMM;
        ctrl_o.alu_op    = ALU_OP_IMM;
      end
      S_I_WB: begin
        ctrl_o.reg_dst    = REG_DST_RT;
        ctrl_o.mem_to_reg = MEM_TO_REG_ALU;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_JR: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PC_SRC_A;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS control sequencer sharing one memory port.
// Optional build macro MC_ILLEGAL_TRAP_EN: unknown opcodes (and syscall)
// halt the core and raise a sticky illegal_op; otherwise they retire as NOPs.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned          OP_W     = 6,
  parameter int unsigned          FUNCT_W  = 6,
  parameter logic [FUNCT_W-1:0]   JR_FUNCT = 6'h08
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               instr_done,
`ifdef MC_ILLEGAL_TRAP_EN
  output logic               illegal_op,
`endif
  output logic [3:0]         state
);

  state_e state_q, state_d;
  logic   nop_done;
  ctrl_t  ctrl, ctrl_g;

  mc_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  // Next-state selection from current state, opcode/funct and mem_ready.
  always_comb begin
    state_d  = state_q;
    nop_done = 1'b0;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                    state_d = S_MEM_ADDR;
          OP_RTYPE:                        state_d = S_EXEC;
          OP_BEQ:                          state_d = S_BRANCH;
          OP_J:                            state_d = S_JUMP;
          OP_JAL:                          state_d = S_JAL;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXEC;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            state_d  = S_FETCH;
            nop_done = 1'b1;
`endif
          end
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_EXEC: begin
        if (funct == JR_FUNCT) state_d = S_JR;
`ifdef MC_ILLEGAL_TRAP_EN
        else if (funct == FUNCT_SYSCALL) state_d = S_HALT;
`endif
        else state_d = S_R_WB;
      end
      S_R_WB:     state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_JAL:      state_d = S_FETCH;
      S_I_EXEC:   state_d = S_I_WB;
      S_I_WB:     state_d = S_FETCH;
      S_JR:       state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky trap flag, set on entry to HALT, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)                                    illegal_q <= 1'b0;
    else if (state_d == S_HALT && state_q != S_HALT) illegal_q <= 1'b1;
  end

  assign illegal_op = illegal_q & ~reset;
`endif

  // Merge the decode-time NOP retire pulse and blank everything during reset.
  always_comb begin
    ctrl_g            = ctrl;
    ctrl_g.instr_done = ctrl.instr_done | nop_done;
    if (reset) ctrl_g = '0;
  end

  assign pc_write      = ctrl_g.pc_write;
  assign pc_write_cond = ctrl_g.pc_write_cond;
  assign i_or_d        = ctrl_g.i_or_d;
  assign mem_read      = ctrl_g.mem_read;
  assign mem_write     = ctrl_g.mem_write;
  assign ir_write      = ctrl_g.ir_write;
  assign reg_dst       = ctrl_g.reg_dst;
  assign mem_to_reg    = ctrl_g.mem_to_reg;
  assign reg_write     = ctrl_g.reg_write;
  assign alu_src_a     = ctrl_g.alu_src_a;
  assign alu_src_b     = ctrl_g.alu_src_b;
  assign alu_op        = ctrl_g.alu_op;
  assign pc_source     = ctrl_g.pc_source;
  assign instr_done    = ctrl_g.instr_done;
  assign state         = state_q;

endmodule
